// File: rtl/alu_seq.sv
// alu_seq: one-at-a-time sequencer for the shared add/sub ALU.
// Executes ADD/SUB/CMP in one ALU cycle, and MUL as WIDTH shift-and-add steps.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_op/
//   req_a/req_b                     request handshake and operands
//   resp_valid/resp_ready/
//   resp_data/resp_cc               response handshake, result, {zero,pos}
//   alu_a/alu_b/alu_op              ALU operand and opcode drive
//   alu_e/alu_cc                    ALU combinational result and cc
module alu_seq #(
  parameter int WIDTH     = 8,
  parameter int MUL_STEPS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [1:0]       resp_cc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_e,
  input  logic [1:0]       alu_cc
);

  localparam int SW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(MUL_STEPS - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // r_opa/r_opb hold A/B; during MUL they act as multiplicand/multiplier.
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [SW-1:0]    r_step;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_cc;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_last    = (r_step == LAST);
  assign w_acc_nxt = r_opb[0] ? alu_e : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = (req_op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_MUL: begin
        if (w_last) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    unique case (1'b1)
      (r_state == S_EXEC): begin
        alu_a  = r_opa;
        alu_b  = r_opb;
        alu_op = (r_op == OP_ADD) ? ALU_ADD : ALU_SUB;
      end
      (r_state == S_MUL): begin
        alu_a  = r_acc;
        alu_b  = r_opa;
        alu_op = ALU_ADD;
      end
      default: begin
      end
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_data;
  assign resp_cc    = r_cc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_ADD;
      r_opa  <= '0;
      r_opb  <= '0;
      r_acc  <= '0;
      r_step <= '0;
      r_data <= '0;
      r_cc   <= 2'b00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= req_op;
            r_opa  <= req_a;
            r_opb  <= req_b;
            r_acc  <= '0;
            r_step <= '0;
          end
        end
        S_EXEC: begin
          unique case (r_op)
            OP_SUB: begin
              r_data <= alu_e;
              r_cc   <= alu_cc;
            end
            OP_CMP: begin
              r_data <= '0;
              r_cc   <= alu_cc;
            end
            default: begin
              r_data <= alu_e;
              r_cc   <= 2'b00;
            end
          endcase
        end
        S_MUL: begin
          r_acc  <= w_acc_nxt;
          r_opa  <= r_opa << 1;
          r_opb  <= r_opb >> 1;
          r_step <= r_step + SW'(1);
          if (w_last) begin
            r_data <= w_acc_nxt;
            r_cc   <= {(w_acc_nxt == '0), 1'b0};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq.
// Models the ALU combinationally and checks results against plain arithmetic.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_data;
  logic [1:0] resp_cc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_e;
  logic [1:0] alu_cc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_e  = (alu_op == 4'h1) ? alu_a - alu_b : alu_a + alu_b;
  assign alu_cc = (alu_op == 4'h1) ?
                  {(alu_e == 8'h00), ($signed(alu_e) > 0)} : 2'b11;

  alu_seq #(.WIDTH(8), .MUL_STEPS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_cc    (resp_cc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_e      (alu_e),
    .alu_cc     (alu_cc)
  );

  function automatic logic [9:0] model(input logic [1:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0]  d;
    logic [15:0] p;
    d = a - b;
    p = 16'(a) * 16'(b);
    case (op)
      2'b00: return {2'b00, 8'(a + b)};
      2'b01: return {(d == 8'h00), ($signed(d) > 0), d};
      2'b10: return {(p[7:0] == 8'h00), 1'b0, p[7:0]};
      default: return {(d == 8'h00), ($signed(d) > 0), 8'h00};
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    return (op == 2'b10) ? 9 : 2;
  endfunction

  task automatic send(input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, output bit ok);
    ok = 1'b0;
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    bit ok;
    int lat;
    logic [9:0] e;
    e = model(op, a, b);
    send(op, a, b, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept: timed out", nm);
    end
    wait_resp(lat);
    checks++;
    if (lat !== exp_lat(op)) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat(op));
    end
    checks++;
    if ({resp_cc, resp_data} !== e) begin
      errors++;
      $display("FAIL %s result: got cc=%b d=%h want cc=%b d=%h",
               nm, resp_cc, resp_data, e[9:8], e[7:0]);
    end
    consume();
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_cc} !== {2'b10, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset: got rdy=%b v=%b d=%h cc=%b want 1 0 00 00",
               req_ready, resp_valid, resp_data, resp_cc);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 20'h0) begin
      errors++;
      $display("FAIL reset_alu: got a=%h b=%h op=%h want 0",
               alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit ok;
    send(2'b10, 8'd13, 8'd11, ok);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_cc} !== {2'b10, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL mid_mul_reset: got rdy=%b v=%b d=%h cc=%b want 1 0 00 00",
               req_ready, resp_valid, resp_data, resp_cc);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL mid_mul_abandon: got v=%b rdy=%b want 0 1",
                 resp_valid, req_ready);
      end
    end
    run_one("post_reset_add", 2'b00, 8'd2, 8'd3);
  endtask

  task automatic test_sub_triplet();
    logic [7:0] as [3] = '{8'd5, 8'd7, 8'd3};
    logic [7:0] bs [3] = '{8'd5, 8'd3, 8'd7};
    bit ok;
    int lat;
    logic [9:0] e;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = model(2'b01, as[i], bs[i]);
      send(2'b01, as[i], bs[i], ok);
      wait_resp(lat);
      checks++;
      if (!ok || lat !== 2) begin
        errors++;
        $display("FAIL sub%0d latency: got ok=%b lat=%0d want 1 2", i, ok, lat);
      end
      checks++;
      if ({resp_cc, resp_data} !== e) begin
        errors++;
        $display("FAIL sub%0d: got cc=%b d=%h want cc=%b d=%h",
                 i, resp_cc, resp_data, e[9:8], e[7:0]);
      end
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_add_cmp();
    run_one("add_wrap", 2'b00, 8'hF0, 8'h20);
    run_one("cmp_gt", 2'b11, 8'h40, 8'h10);
    run_one("cmp_eq", 2'b11, 8'h22, 8'h22);
    run_one("sub_ovf", 2'b01, 8'h7F, 8'h80);
  endtask

  task automatic test_mul();
    logic [7:0] as [3] = '{8'd13, 8'd20, 8'd0};
    logic [7:0] bs [3] = '{8'd11, 8'd20, 8'hFF};
    bit ok;
    int lat;
    logic [9:0] e;
    for (int i = 0; i < 3; i++) begin
      e = model(2'b10, as[i], bs[i]);
      send(2'b10, as[i], bs[i], ok);
      lat = 1;
      while (!resp_valid && lat < 40) begin
        checks++;
        if (alu_op !== 4'h0) begin
          errors++;
          $display("FAIL mul%0d alu_op step %0d: got %h want 0", i, lat, alu_op);
        end
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (!ok || lat !== 9) begin
        errors++;
        $display("FAIL mul%0d latency: got ok=%b lat=%0d want 1 9", i, ok, lat);
      end
      checks++;
      if ({resp_cc, resp_data} !== e) begin
        errors++;
        $display("FAIL mul%0d: got cc=%b d=%h want cc=%b d=%h",
                 i, resp_cc, resp_data, e[9:8], e[7:0]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [9:0] e1;
    logic [9:0] e2;
    e1 = model(2'b01, 8'h10, 8'h30);
    e2 = model(2'b00, 8'h44, 8'h11);
    send(2'b01, 8'h10, 8'h30, ok);
    wait_resp(lat);
    req_op = 2'b00;
    req_a = 8'h44;
    req_b = 8'h11;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, req_ready, resp_cc, resp_data} !== {2'b10, e1}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b rdy=%b cc=%b d=%h want 1 0 %b %h",
                 i, resp_valid, req_ready, resp_cc, resp_data, e1[9:8], e1[7:0]);
      end
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_idle: got rdy=%b v=%b want 1 0", req_ready, resp_valid);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got rdy=%b want 0", req_ready);
    end
    wait_resp(lat);
    checks++;
    if ({resp_valid, resp_cc, resp_data} !== {1'b1, e2} || lat !== 2) begin
      errors++;
      $display("FAIL bp_second: got v=%b cc=%b d=%h lat=%0d want 1 %b %h 2",
               resp_valid, resp_cc, resp_data, lat, e2[9:8], e2[7:0]);
    end
    consume();
  endtask

  task automatic test_idle();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({alu_a, alu_b, alu_op, resp_valid} !== 21'h0) begin
      errors++;
      $display("FAIL idle_alu: got a=%h b=%h op=%h v=%b want 0",
               alu_a, alu_b, alu_op, resp_valid);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL idle_pulse: got rdy=%b v=%b want 1 0", req_ready, resp_valid);
    end
    run_one("idle_after", 2'b00, 8'h01, 8'h01);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      run_one($sformatf("rnd%0d", i), op, a, b);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset_mid_mul();
    test_sub_triplet();
    test_add_cmp();
    test_mul();
    test_backpressure();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
